// File: rtl/mc_sequencer_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the MIPS datapath.
// master = sequencer side, slave = datapath/memory/mul-div side.
interface mc_sequencer_if;
    logic [2:0] op_class;
    logic       is_muldiv;
    logic       branch_taken;
    logic       mem_ready;
    logic       muldiv_done;

    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic [1:0] pc_sel;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] alu_op_sel;
    logic [1:0] wb_sel;
    logic [1:0] rd_sel;
    logic       muldiv_start;
    logic       instr_done;

    modport master (
        input  op_class, is_muldiv, branch_taken, mem_ready, muldiv_done,
        output state, mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we,
               pc_sel, alu_a_sel, alu_b_sel, alu_op_sel, wb_sel, rd_sel,
               muldiv_start, instr_done
    );

    modport slave (
        output op_class, is_muldiv, branch_taken, mem_ready, muldiv_done,
        input  state, mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we,
               pc_sel, alu_a_sel, alu_b_sel, alu_op_sel, wb_sel, rd_sel,
               muldiv_start, instr_done
    );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer with memory and mul/div handshakes.
// Outputs are combinational from state, latched instruction class and live handshakes.
module mc_sequencer (
    input  logic           clk,
    input  logic           rst,
    mc_sequencer_if.master bus
);
    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;
    localparam logic [2:0] S_MD  = 3'd5;

    localparam logic [2:0] C_ALU_R  = 3'd0;
    localparam logic [2:0] C_ALU_I  = 3'd1;
    localparam logic [2:0] C_LOAD   = 3'd2;
    localparam logic [2:0] C_STORE  = 3'd3;
    localparam logic [2:0] C_BRANCH = 3'd4;
    localparam logic [2:0] C_J      = 3'd5;
    localparam logic [2:0] C_JAL    = 3'd6;
    localparam logic [2:0] C_JR     = 3'd7;

    logic [2:0] state_q, state_d;
    logic [2:0] cls_q, cls_d;
    logic       md_q, md_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF;
            cls_q   <= C_ALU_R;
            md_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            md_q    <= md_d;
        end
    end

    assign bus.state = rst ? S_IF : state_q;

    always_comb begin
        state_d          = state_q;
        cls_d            = cls_q;
        md_d             = md_q;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.addr_sel     = 1'b0;
        bus.ir_we        = 1'b0;
        bus.pc_we        = 1'b0;
        bus.reg_we       = 1'b0;
        bus.pc_sel       = 2'b00;
        bus.alu_a_sel    = 2'b00;
        bus.alu_b_sel    = 2'b00;
        bus.alu_op_sel   = 2'b00;
        bus.wb_sel       = 2'b00;
        bus.rd_sel       = 2'b00;
        bus.muldiv_start = 1'b0;
        bus.instr_done   = 1'b0;

        case (state_q)
            S_IF: begin
                bus.mem_req   = 1'b1;
                bus.alu_b_sel = 2'b01;
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    bus.pc_we = 1'b1;
                    state_d   = S_ID;
                end
            end
            S_ID: begin
                bus.alu_b_sel = 2'b11;
                cls_d         = bus.op_class;
                md_d          = bus.is_muldiv;
                state_d       = S_EX;
            end
            S_EX: begin
                case (cls_q)
                    C_ALU_R: begin
                        bus.alu_a_sel    = 2'b01;
                        bus.alu_op_sel   = 2'b10;
                        bus.muldiv_start = md_q;
                        state_d          = md_q ? S_MD : S_WB;
                    end
                    C_ALU_I: begin
                        bus.alu_a_sel  = 2'b01;
                        bus.alu_b_sel  = 2'b10;
                        bus.alu_op_sel = 2'b10;
                        state_d        = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        bus.alu_a_sel = 2'b01;
                        bus.alu_b_sel = 2'b10;
                        state_d       = S_MEM;
                    end
                    C_BRANCH: begin
                        bus.alu_a_sel  = 2'b01;
                        bus.alu_op_sel = 2'b01;
                        bus.pc_we      = bus.branch_taken;
                        bus.pc_sel     = 2'b01;
                        bus.instr_done = 1'b1;
                        state_d        = S_IF;
                    end
                    C_J: begin
                        bus.pc_we      = 1'b1;
                        bus.pc_sel     = 2'b10;
                        bus.instr_done = 1'b1;
                        state_d        = S_IF;
                    end
                    C_JAL: begin
                        bus.pc_we  = 1'b1;
                        bus.pc_sel = 2'b10;
                        state_d    = S_WB;
                    end
                    default: begin
                        bus.pc_we      = 1'b1;
                        bus.pc_sel     = 2'b11;
                        bus.instr_done = 1'b1;
                        state_d        = S_IF;
                    end
                endcase
            end
            S_MEM: begin
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                bus.mem_we   = (cls_q == C_STORE);
                if (bus.mem_ready) begin
                    bus.instr_done = (cls_q == C_STORE);
                    state_d        = (cls_q == C_STORE) ? S_IF : S_WB;
                end
            end
            S_WB: begin
                bus.reg_we     = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_IF;
                case (cls_q)
                    C_ALU_R: bus.rd_sel = 2'b01;
                    C_LOAD:  bus.wb_sel = 2'b01;
                    C_JAL: begin
                        bus.wb_sel = 2'b10;
                        bus.rd_sel = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_MD: begin
                if (bus.muldiv_done) begin
                    bus.instr_done = 1'b1;
                    state_d        = S_IF;
                end
            end
            default: state_d = S_IF;
        endcase

        // Reset abandons the instruction: selects may still follow state, but nothing is written.
        if (rst) begin
            state_d          = S_IF;
            bus.mem_req      = 1'b0;
            bus.mem_we       = 1'b0;
            bus.ir_we        = 1'b0;
            bus.pc_we        = 1'b0;
            bus.reg_we       = 1'b0;
            bus.muldiv_start = 1'b0;
            bus.instr_done   = 1'b0;
        end
    end
endmodule
